// File: rtl/vanilla_decode_buffer.sv
// RV32IMAF decode-on-enqueue buffer: els_p-deep FIFO of decoded control bundles.
// Optional feature macro: VANILLA_DECODE_BUF_ILLEGAL_CNT_EN (saturating illegal-dequeue counter).
module vanilla_decode_buffer #(
    parameter int els_p         = 2,
    parameter int pc_width_p    = 22,
    parameter int class_width_p = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         flush_i,
    input  logic                         v_i,
    input  logic [31:0]                  instr_i,
    input  logic [pc_width_p-1:0]        pc_i,
    output logic                         ready_o,
    output logic                         v_o,
    input  logic                         yumi_i,
    output logic [31:0]                  instr_o,
    output logic [pc_width_p-1:0]        pc_o,
    output logic [class_width_p-1:0]     op_class_o,
    output logic [4:0]                   rd_o,
    output logic [4:0]                   rs1_o,
    output logic [4:0]                   rs2_o,
    output logic                         write_rd_o,
    output logic                         write_frd_o,
    output logic                         read_rs1_o,
    output logic                         read_rs2_o,
    output logic                         read_frs1_o,
    output logic                         read_frs2_o,
    output logic                         read_frs3_o,
    output logic                         illegal_o,
    output logic [$clog2(els_p+1)-1:0]   count_o,
    output logic [15:0]                  illegal_cnt_o
);

    localparam int addr_w = $clog2(els_p);
    localparam int ptr_w  = addr_w + 1;
    localparam int cnt_w  = $clog2(els_p + 1);

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

    localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;

    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_LOAD    = 4'd1,
        CLS_STORE   = 4'd2,
        CLS_BRANCH  = 4'd3,
        CLS_JAL     = 4'd4,
        CLS_JALR    = 4'd5,
        CLS_IMUL    = 4'd6,
        CLS_IDIV    = 4'd7,
        CLS_ATOMIC  = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_CSR     = 4'd10,
        CLS_MRET    = 4'd11,
        CLS_FP      = 4'd12,
        CLS_ILLEGAL = 4'd15
    } op_class_e;

    typedef struct packed {
        op_class_e op_class;
        logic      write_rd;
        logic      write_frd;
        logic      read_rs1;
        logic      read_rs2;
        logic      read_frs1;
        logic      read_frs2;
        logic      read_frs3;
        logic      illegal;
    } ctrl_s;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    ctrl_s      dec;
    logic       bad;
    logic [2:0] funct3;
    logic [4:0] funct5;
    logic [6:0] funct7;

    assign funct3 = instr_i[14:12];
    assign funct5 = instr_i[31:27];
    assign funct7 = instr_i[31:25];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec          = '0;
        dec.op_class = CLS_ALU;
        bad          = 1'b0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: dec.write_rd = 1'b1;
            OPC_OP_IMM: begin
                dec.write_rd = 1'b1;
                dec.read_rs1 = 1'b1;
            end
            OPC_OP: begin
                dec.write_rd = 1'b1;
                dec.read_rs1 = 1'b1;
                dec.read_rs2 = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (funct3 == 3'b000)  dec.op_class = CLS_IMUL;
                    else if (funct3[2])    dec.op_class = CLS_IDIV;
                    else                   bad = 1'b1;  // MULH/MULHSU/MULHU unsupported
                end
            end
            OPC_JAL: begin
                dec.op_class = CLS_JAL;
                dec.write_rd = 1'b1;
            end
            OPC_JALR: begin
                dec.op_class = CLS_JALR;
                dec.write_rd = 1'b1;
                dec.read_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.op_class = CLS_BRANCH;
                dec.read_rs1 = 1'b1;
                dec.read_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.op_class = CLS_LOAD;
                dec.write_rd = 1'b1;
                dec.read_rs1 = 1'b1;
            end
            OPC_LOAD_FP: begin
                dec.op_class  = CLS_LOAD;
                dec.write_frd = 1'b1;
                dec.read_rs1  = 1'b1;
            end
            OPC_STORE: begin
                dec.op_class = CLS_STORE;
                dec.read_rs1 = 1'b1;
                dec.read_rs2 = 1'b1;
            end
            OPC_STORE_FP: begin
                dec.op_class  = CLS_STORE;
                dec.read_rs1  = 1'b1;
                dec.read_frs2 = 1'b1;
            end
            OPC_AMO: begin
                dec.op_class = CLS_ATOMIC;
                dec.write_rd = 1'b1;
                dec.read_rs1 = 1'b1;
                case (funct5)
                    5'b00010:                   dec.read_rs2 = 1'b0;  // LR.W
                    5'b00000, 5'b00001, 5'b01000: dec.read_rs2 = 1'b1;
                    default:                    bad = 1'b1;
                endcase
            end
            OPC_MISC_MEM: dec.op_class = CLS_FENCE;
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    if (instr_i == INSTR_MRET) dec.op_class = CLS_MRET;
                    else                       bad = 1'b1;
                end else if (funct3 == 3'b100) begin
                    bad = 1'b1;
                end else begin
                    dec.op_class = CLS_CSR;
                    dec.write_rd = 1'b1;
                    dec.read_rs1 = ~funct3[2];  // immediate forms carry a zimm, not rs1
                end
            end
            OPC_OP_FP: begin
                dec.op_class = CLS_FP;
                case (funct7)
                    7'b1010000: begin  // FEQ/FLT/FLE
                        dec.write_rd  = 1'b1;
                        dec.read_frs1 = 1'b1;
                        dec.read_frs2 = 1'b1;
                    end
                    7'b1100000, 7'b1110000: begin  // FCVT.W[U].S, FMV.X.W/FCLASS
                        dec.write_rd  = 1'b1;
                        dec.read_frs1 = 1'b1;
                    end
                    7'b1101000, 7'b1111000: begin  // FCVT.S.W[U], FMV.W.X
                        dec.write_frd = 1'b1;
                        dec.read_rs1  = 1'b1;
                    end
                    7'b0101100: begin  // FSQRT
                        dec.write_frd = 1'b1;
                        dec.read_frs1 = 1'b1;
                    end
                    default: begin
                        dec.write_frd = 1'b1;
                        dec.read_frs1 = 1'b1;
                        dec.read_frs2 = 1'b1;
                    end
                endcase
            end
            OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                dec.op_class  = CLS_FP;
                dec.write_frd = 1'b1;
                dec.read_frs1 = 1'b1;
                dec.read_frs2 = 1'b1;
                dec.read_frs3 = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (instr_i[1:0] != 2'b11) bad = 1'b1;

        if (bad) begin
            dec          = '0;
            dec.op_class = CLS_ILLEGAL;
            dec.illegal  = 1'b1;
        end
        if (instr_i[11:7] == 5'd0) dec.write_rd = 1'b0;
    end

    // ------------------------------------------------------------------
    // FIFO pointers and handshakes
    // ------------------------------------------------------------------
    logic [ptr_w-1:0] wptr, rptr;
    logic             full, empty, enq, deq;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[ptr_w-1] != rptr[ptr_w-1]) && (wptr[addr_w-1:0] == rptr[addr_w-1:0]);
    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign count_o = cnt_w'(wptr - rptr);
    assign enq     = v_i & ready_o & ~flush_i;
    assign deq     = yumi_i & v_o & ~flush_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq) wptr <= wptr + ptr_w'(1);
            if (deq) rptr <= rptr + ptr_w'(1);
        end
    end

    ctrl_s                  ctrl_mem  [els_p];
    logic [31:0]            instr_mem [els_p];
    logic [pc_width_p-1:0]  pc_mem    [els_p];

    // NOTE: entry storage has no reset; v_o qualifies it, and skipping the reset keeps it plain RAM.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            ctrl_mem[wptr[addr_w-1:0]]  <= dec;
            instr_mem[wptr[addr_w-1:0]] <= instr_i;
            pc_mem[wptr[addr_w-1:0]]    <= pc_i;
        end
    end

    ctrl_s head;
    assign head        = ctrl_mem[rptr[addr_w-1:0]];
    assign instr_o     = instr_mem[rptr[addr_w-1:0]];
    assign pc_o        = pc_mem[rptr[addr_w-1:0]];
    assign op_class_o  = class_width_p'(head.op_class);
    assign rd_o        = instr_o[11:7];
    assign rs1_o       = instr_o[19:15];
    assign rs2_o       = instr_o[24:20];
    assign write_rd_o  = head.write_rd;
    assign write_frd_o = head.write_frd;
    assign read_rs1_o  = head.read_rs1;
    assign read_rs2_o  = head.read_rs2;
    assign read_frs1_o = head.read_frs1;
    assign read_frs2_o = head.read_frs2;
    assign read_frs3_o = head.read_frs3;
    assign illegal_o   = head.illegal;

`ifdef VANILLA_DECODE_BUF_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            illegal_cnt_q <= '0;
        else if (deq && head.illegal && (illegal_cnt_q != 16'hFFFF))
            illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end

    assign illegal_cnt_o = illegal_cnt_q;
`else
    assign illegal_cnt_o = '0;
`endif

    // Consumer must only take an entry that is actually presented.
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_vanilla_decode_buffer.sv
// Self-checking bench for vanilla_decode_buffer: queue-based reference model plus directed checks.
module tb_vanilla_decode_buffer;

    localparam int ELS = 2;
    localparam int PCW = 22;
    localparam int CW  = 4;

    logic             clk_i = 1'b0;
    logic             reset_n_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             v_i = 1'b0;
    logic [31:0]      instr_i = '0;
    logic [PCW-1:0]   pc_i = '0;
    logic             ready_o, v_o;
    logic             yumi_i = 1'b0;
    logic [31:0]      instr_o;
    logic [PCW-1:0]   pc_o;
    logic [CW-1:0]    op_class_o;
    logic [4:0]       rd_o, rs1_o, rs2_o;
    logic             write_rd_o, write_frd_o, read_rs1_o, read_rs2_o;
    logic             read_frs1_o, read_frs2_o, read_frs3_o, illegal_o;
    logic [$clog2(ELS+1)-1:0] count_o;
    logic [15:0]      illegal_cnt_o;

    vanilla_decode_buffer #(.els_p(ELS), .pc_width_p(PCW), .class_width_p(CW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .v_i(v_i),
        .instr_i(instr_i), .pc_i(pc_i), .ready_o(ready_o), .v_o(v_o), .yumi_i(yumi_i),
        .instr_o(instr_o), .pc_o(pc_o), .op_class_o(op_class_o),
        .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .write_rd_o(write_rd_o), .write_frd_o(write_frd_o),
        .read_rs1_o(read_rs1_o), .read_rs2_o(read_rs2_o),
        .read_frs1_o(read_frs1_o), .read_frs2_o(read_frs2_o), .read_frs3_o(read_frs3_o),
        .illegal_o(illegal_o), .count_o(count_o), .illegal_cnt_o(illegal_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference decode: a table of instruction families
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0] cls;
        logic wrd, wfrd, r1, r2, f1, f2, f3, ill;
    } dec_t;

    function automatic dec_t mk(input int cls, input bit wrd, input bit wfrd, input bit r1,
                                input bit r2, input bit f1, input bit f2, input bit f3);
        dec_t d;
        d.cls = cls[3:0]; d.wrd = wrd; d.wfrd = wfrd; d.r1 = r1; d.r2 = r2;
        d.f1 = f1; d.f2 = f2; d.f3 = f3; d.ill = 1'b0;
        return d;
    endfunction

    function automatic dec_t model_decode(input logic [31:0] ins);
        dec_t       d;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [4:0] f5 = ins[31:27];
        d     = '0;
        d.cls = 4'd15;
        d.ill = 1'b1;
        if (ins[1:0] == 2'b11) begin
            case (ins[6:0])
                7'h37, 7'h17: d = mk(0, 1, 0, 0, 0, 0, 0, 0);
                7'h13:        d = mk(0, 1, 0, 1, 0, 0, 0, 0);
                7'h33: begin
                    if (f7 != 7'h01)   d = mk(0, 1, 0, 1, 1, 0, 0, 0);
                    else if (f3 == 0)  d = mk(6, 1, 0, 1, 1, 0, 0, 0);
                    else if (f3 >= 4)  d = mk(7, 1, 0, 1, 1, 0, 0, 0);
                end
                7'h6F: d = mk(4, 1, 0, 0, 0, 0, 0, 0);
                7'h67: d = mk(5, 1, 0, 1, 0, 0, 0, 0);
                7'h63: d = mk(3, 0, 0, 1, 1, 0, 0, 0);
                7'h03: d = mk(1, 1, 0, 1, 0, 0, 0, 0);
                7'h07: d = mk(1, 0, 1, 1, 0, 0, 0, 0);
                7'h23: d = mk(2, 0, 0, 1, 1, 0, 0, 0);
                7'h27: d = mk(2, 0, 0, 1, 0, 0, 1, 0);
                7'h2F: begin
                    if (f5 == 5'd2)                       d = mk(8, 1, 0, 1, 0, 0, 0, 0);
                    else if (f5 == 0 || f5 == 1 || f5 == 8) d = mk(8, 1, 0, 1, 1, 0, 0, 0);
                end
                7'h0F: d = mk(9, 0, 0, 0, 0, 0, 0, 0);
                7'h73: begin
                    if (ins == 32'h30200073)      d = mk(11, 0, 0, 0, 0, 0, 0, 0);
                    else if (f3 != 0 && f3 != 4)  d = mk(10, 1, 0, (f3 < 4), 0, 0, 0, 0);
                end
                7'h53: begin
                    if (f7 == 7'h50)                    d = mk(12, 1, 0, 0, 0, 1, 1, 0);
                    else if (f7 == 7'h60 || f7 == 7'h70) d = mk(12, 1, 0, 0, 0, 1, 0, 0);
                    else if (f7 == 7'h68 || f7 == 7'h78) d = mk(12, 0, 1, 1, 0, 0, 0, 0);
                    else if (f7 == 7'h2C)               d = mk(12, 0, 1, 0, 0, 1, 0, 0);
                    else                                d = mk(12, 0, 1, 0, 0, 1, 1, 0);
                end
                7'h43, 7'h47, 7'h4B, 7'h4F: d = mk(12, 0, 1, 0, 0, 1, 1, 1);
                default: ;
            endcase
        end
        if (ins[11:7] == 5'd0) d.wrd = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [20];
        logic [6:0]  fp7 [9];
        logic [4:0]  amo5 [6];
        logic [6:0]  op7 [3];
        int          k;
        ops  = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h07, 7'h23,
                 7'h27, 7'h2F, 7'h0F, 7'h73, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h33};
        fp7  = '{7'h00, 7'h08, 7'h2C, 7'h50, 7'h60, 7'h70, 7'h68, 7'h78, 7'h14};
        amo5 = '{5'd0, 5'd1, 5'd2, 5'd8, 5'd3, 5'd4};
        op7  = '{7'h00, 7'h20, 7'h01};
        r = $urandom;
        k = $urandom_range(0, 22);
        if (k < 20) r[6:0] = ops[k];
        else if (k == 20) r = 32'h30200073;
        else if (k == 21) r[1:0] = 2'($urandom_range(0, 2));
        case (r[6:0])
            7'h33: r[31:25] = op7[$urandom_range(0, 2)];
            7'h2F: r[31:27] = amo5[$urandom_range(0, 5)];
            7'h53: r[31:25] = fp7[$urandom_range(0, 8)];
            7'h73: if ($urandom_range(0, 2) == 0) r[14:12] = 3'd0;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference FIFO state, updated on the same edge as the DUT
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0]    instr;
        logic [PCW-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   model_icnt = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            q.delete();
            model_icnt = 0;
        end else begin
            bit can_enq;
            can_enq = (q.size() != ELS);
            if (flush_i) begin
                q.delete();
            end else begin
                if (yumi_i && q.size() > 0) begin
                    if (model_decode(q[0].instr).ill && model_icnt < 65535) model_icnt++;
                    void'(q.pop_front());
                end
                if (v_i && can_enq) q.push_back('{instr_i, pc_i});
            end
        end
    end

    function automatic logic [15:0] exp_icnt();
`ifdef VANILLA_DECODE_BUF_ILLEGAL_CNT_EN
        return 16'(model_icnt);
`else
        return 16'h0;
`endif
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en && reset_n_i) begin
            check("ready", ready_o, q.size() != ELS);
            check("v_o", v_o, q.size() != 0);
            check("count", count_o, q.size());
            check("illegal_cnt", illegal_cnt_o, exp_icnt());
            if (q.size() != 0) begin
                dec_t d;
                d = model_decode(q[0].instr);
                check("instr", instr_o, q[0].instr);
                check("pc", pc_o, q[0].pc);
                check("op_class", op_class_o, d.cls);
                check("rd", rd_o, q[0].instr[11:7]);
                check("rs1", rs1_o, q[0].instr[19:15]);
                check("rs2", rs2_o, q[0].instr[24:20]);
                check("write_rd", write_rd_o, d.wrd);
                check("write_frd", write_frd_o, d.wfrd);
                check("read_rs1", read_rs1_o, d.r1);
                check("read_rs2", read_rs2_o, d.r2);
                check("read_frs1", read_frs1_o, d.f1);
                check("read_frs2", read_frs2_o, d.f2);
                check("read_frs3", read_frs3_o, d.f3);
                check("illegal", illegal_o, d.ill);
            end
        end
    end

    // Drive one cycle of inputs, then return just after the capturing edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [PCW-1:0] pc,
                        input bit y, input bit fl);
        v_i = v; instr_i = ins; pc_i = pc; yumi_i = y; flush_i = fl;
        @(posedge clk_i);
        #1;
        v_i = 1'b0; yumi_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        dec_t d;

        // Literal expectations that pin the reference decoder itself.
        d = model_decode(32'h00500093);
        check("pin_addi", {d.cls, d.wrd, d.r1, d.r2, d.ill}, {4'd0, 4'b1100});
        d = model_decode(32'h02209033);
        check("pin_mulh", {d.cls, d.wrd, d.ill}, {4'd15, 2'b01});
        d = model_decode(32'h0020A027);  // fsw f2,0(x1)
        check("pin_fsw", {d.cls, d.r1, d.f2, d.wfrd}, {4'd2, 3'b110});
        d = model_decode(32'h0000A107);  // flw f2,0(x1)
        check("pin_flw", {d.cls, d.wfrd, d.r1, d.wrd}, {4'd1, 3'b110});
        d = model_decode(32'h30200073);
        check("pin_mret", {d.cls, d.ill}, {4'd11, 1'b0});
        d = model_decode(32'h00500090);
        check("pin_lowbits", {d.cls, d.ill}, {4'd15, 1'b1});

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_v_o", v_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_count", count_o, 0);
        reset_n_i = 1'b1;
        chk_en    = 1'b1;
        step(0, '0, '0, 0, 0);

        // addi x1,x0,5
        step(1, 32'h00500093, 22'h10, 0, 0);
        check("addi_v_o", v_o, 1'b1);
        check("addi_class", op_class_o, 4'd0);
        check("addi_rd", rd_o, 5'd1);
        check("addi_wrd", write_rd_o, 1'b1);
        check("addi_rs1", read_rs1_o, 1'b1);
        check("addi_rs2", read_rs2_o, 1'b0);
        check("addi_ill", illegal_o, 1'b0);
        check("addi_pc", pc_o, 22'h10);
        step(0, '0, '0, 1, 0);

        // addi x0 and mulh
        step(1, 32'h00500013, 22'h14, 0, 0);
        check("addi_x0_wrd", write_rd_o, 1'b0);
        step(0, '0, '0, 1, 0);
        step(1, 32'h02209033, 22'h18, 0, 0);
        check("mulh_class", op_class_o, 4'd15);
        check("mulh_ill", illegal_o, 1'b1);
        check("mulh_wrd", write_rd_o, 1'b0);
        step(0, '0, '0, 1, 0);

        // Fill to full, third push rejected, then drain in order.
        step(1, 32'h00100093, 22'h20, 0, 0);
        step(1, 32'h00200113, 22'h21, 0, 0);
        check("full_ready_before3", ready_o, 1'b0);
        step(1, 32'h00300193, 22'h22, 0, 0);
        check("full_ready", ready_o, 1'b0);
        check("full_count", count_o, 2);
        check("full_head", instr_o, 32'h00100093);
        step(0, '0, '0, 1, 0);
        check("deq_ready", ready_o, 1'b1);
        check("deq_head", instr_o, 32'h00200113);
        step(0, '0, '0, 1, 0);
        check("drained", v_o, 1'b0);

        // Flush with two entries and a same-cycle push.
        step(1, 32'h00100093, 22'h30, 0, 0);
        step(1, 32'h00200113, 22'h31, 0, 0);
        step(1, 32'h00400213, 22'h32, 0, 1);
        check("flush_v_o", v_o, 1'b0);
        check("flush_count", count_o, 0);
        step(0, '0, '0, 0, 0);
        check("flush_no_ghost", v_o, 1'b0);

        // Asynchronous reset mid-cycle with one entry.
        step(1, 32'h00100093, 22'h40, 0, 0);
        #2 reset_n_i = 1'b0;
        #1;
        check("arst_v_o", v_o, 1'b0);
        check("arst_count", count_o, 0);
        #2 reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_empty", v_o, 1'b0);
        step(1, 32'h00700393, 22'h41, 0, 0);
        check("post_rst_v_o", v_o, 1'b1);
        check("post_rst_instr", instr_o, 32'h00700393);
        step(0, '0, '0, 1, 0);

        // Illegal-dequeue counter.
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h02209033, 22'h50, 0, 0);
            step(0, '0, '0, 1, 0);
        end
`ifdef VANILLA_DECODE_BUF_ILLEGAL_CNT_EN
        check("icnt_3", illegal_cnt_o, 16'd3);
        force dut.illegal_cnt_q = 16'hFFFE;
        #1;
        release dut.illegal_cnt_q;
        model_icnt = 65534;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h02209033, 22'h51, 0, 0);
            step(0, '0, '0, 1, 0);
        end
        check("icnt_sat", illegal_cnt_o, 16'hFFFF);
`else
        check("icnt_off", illegal_cnt_o, 16'd0);
`endif

        // Randomized traffic; the first phase rarely consumes so the buffer sits full.
        for (int i = 0; i < 3000; i++) begin
            bit v, y, fl;
            v  = ($urandom_range(0, 3) != 0);
            y  = (q.size() != 0) && ($urandom_range(0, 9) < ((i < 1000) ? 2 : 7));
            fl = ($urandom_range(0, 59) == 0);
            step(v, rand_instr(), PCW'($urandom), y, fl);
        end

        step(0, '0, '0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vanilla_decode_buffer.md
Name: vanilla_decode_buffer

Overview:
- Registered, parametrised decode stage between instruction fetch and the vanilla execute pipeline.
- Decodes each fetched RV32IMAF instruction on enqueue into a compact control bundle plus an op-class code.
- Holds decoded entries in an els_p-deep FIFO with valid/ready handshakes on both sides.
- Supports a single-cycle flush for branch/jump redirects and flags illegal or unsupported encodings instead of silently decoding them.

Parameters:
- els_p, 2, FIFO depth; power of two, >=2.
- pc_width_p, 22, width of the word-address PC carried with each instruction.
- class_width_p, 4, width of the op-class field; must be >=4.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all buffered entries and any same-cycle input.
- v_i  in  1  fetch instruction valid.
- instr_i  in  32  fetched instruction.
- pc_i  in  pc_width_p  PC of instr_i.
- ready_o  out  1  buffer can accept this cycle.
- v_o  out  1  head entry valid.
- yumi_i  in  1  consumer takes head entry; legal only when v_o=1.
- instr_o  out  32  head instruction.
- pc_o  out  pc_width_p  head PC.
- op_class_o  out  class_width_p  head op class.
- rd_o / rs1_o / rs2_o  out  5 each  register fields.
- write_rd_o  out  1  integer RF write; 0 when rd=0.
- write_frd_o  out  1  FP RF write, including FLW.
- read_rs1_o / read_rs2_o  out  1 each  integer RF read enables.
- read_frs1_o / read_frs2_o / read_frs3_o  out  1 each  FP RF read enables; FSW sets read_frs2_o.
- illegal_o  out  1  head entry is illegal or unsupported.
- count_o  out  $clog2(els_p+1)  occupancy.
- illegal_cnt_o  out  16  illegal-dequeue counter; see Optional Feature.

Behaviour:
- Reset (async on reset_n_i low): read/write pointers=0, count_o=0, v_o=0, ready_o=1. Data outputs reflect stale head storage but are don't-care while v_o=0. Reset mid-operation drops all entries immediately.
- Enqueue: v_i & ready_o & ~flush_i at cycle N. Decode is combinational on instr_i and is written with pc_i into storage. Earliest v_o=1 is cycle N+1; there is no same-cycle bypass.
- ready_o = (count_o != els_p). It does not depend on yumi_i; no full-with-dequeue pass-through.
- Dequeue: yumi_i at cycle N advances the read pointer; the next entry appears at N+1.
- Simultaneous enqueue and dequeue when not full: count_o unchanged.
- Pointers are $clog2(els_p)+1 bits. Full when MSBs differ and low bits are equal; empty when the pointers are equal. Wrap-around is natural binary overflow.
- flush_i has priority over v_i and yumi_i: next cycle pointers=0 and count_o=0.
- yumi_i with v_o=0 is a protocol violation: assertion fires and state is unchanged.
- Op-class encoding:
  - 0 ALU: OP, OP_IMM, LUI, AUIPC.
  - 1 LOAD: incl. FLW.
  - 2 STORE: incl. FSW.
  - 3 BRANCH.
  - 4 JAL.
  - 5 JALR.
  - 6 IMUL: MUL only.
  - 7 IDIV: DIV/DIVU/REM/REMU.
  - 8 ATOMIC: LR.W, AMOSWAP/AMOOR/AMOADD.
  - 9 FENCE/BARSEND/BARRECV.
  - 10 CSR: all six CSR funct3.
  - 11 MRET.
  - 12 FP: OP_FP and FMA opcodes.
  - 15 ILLEGAL.
- Illegal (class 15, illegal_o=1, all write/read enables 0):
  - unknown major opcode;
  - MULH/MULHSU/MULHU;
  - AMO funct5 outside swap/or/add/lr;
  - SYSTEM funct3=0 other than MRET;
  - instr[1:0] != 2'b11.
- Enable rules:
  - write_rd_o for LUI, AUIPC, JAL, JALR, LOAD, OP, OP_IMM, AMO, CSR, and FP ops writing the integer RF (FEQ/FLT/FLE, FCLASS, FMV.X.W, FCVT.W[U].S); forced 0 if rd=0.
  - read_rs2_o for BRANCH, STORE, OP, and AMO except LR.
  - FP moves/converts from integer set read_rs1_o, not read_frs1_o.

Optional Feature:
- Macro VANILLA_DECODE_BUF_ILLEGAL_CNT_EN.
- When defined: illegal_cnt_o is a 16-bit saturating count of dequeues (yumi_i) whose head has illegal_o=1.
  - Reset to 0; holds at 16'hFFFF.
  - Not cleared by flush_i.
- When undefined: illegal_cnt_o is tied to 0 and no counter flops are generated.

Test Plan:
- Enqueue 0x00500093 (addi x1,x0,5), pc=0x10; yumi_i held 0 → next cycle v_o=1, op_class_o=0, rd_o=1, write_rd_o=1, read_rs1_o=1, read_rs2_o=0, illegal_o=0, pc_o=0x10.
- Enqueue 0x00500013 (addi x0) → write_rd_o=0. Enqueue 0x02209033 (mulh) → op_class_o=15, illegal_o=1, write_rd_o=0.
- els_p=2, yumi_i=0, v_i=1 for three cycles → first two accepted, ready_o=0 on the third, count_o=2. Then yumi_i=1 one cycle → ready_o=1 next cycle, FIFO order preserved.
- With 2 entries, assert flush_i together with v_i=1 → next cycle v_o=0, count_o=0. The flushed-cycle instruction never appears.
- Deassert reset_n_i asynchronously mid-cycle with 1 entry → v_o=0 and count_o=0 immediately. After release, the first enqueue returns data at N+1.
- With the macro defined: 3 illegal dequeues → illegal_cnt_o=3. Preload 16'hFFFE then 3 illegal dequeues → 16'hFFFF. With the macro undefined → always 0.
